datapath_xyz: RTL and testbench
===============================

// Module: datapath_xyz
// PURPOSE
// - Register/ALU datapath driven by the controle decoder: registers X, Y, Z plus a WIDTH-bit ALU (ula).
// - Consumes tx/ty/tz (per-register 2-bit commands) and tula (3-bit ALU op), one command set per enabled clock.
// - X takes the external operand; Y accumulates the ALU result; Z latches Y for the display stage.
// - Sits directly downstream of controle: the controle outputs are registered, so each instruction executes
//   one cycle after controle samples it.
// PARAMETERS
// - WIDTH  4  data width of X, Y, Z, ALU operands and result
// PORTS
// - clock     in   1      rising-edge clock
// - reset     in   1      synchronous, active-high; clears all state
// - enable    in   1      1 = apply commands this edge; 0 = every register holds
// - tx        in   2      X command (see encoding)
// - ty        in   2      Y command
// - tz        in   2      Z command
// - tula      in   3      ALU operation
// - data_in   in   WIDTH  operand loaded into X
// - z_out     out  WIDTH  Z register (display value)
// - y_out     out  WIDTH  Y register (accumulator, debug/observe)
// - flag_c    out  1      carry/borrow/shifted-out bit of the last Y load
// - flag_v    out  1      signed overflow of the last Y load
// - flag_z    out  1      last Y load produced 0
// - z_strobe  out  1      one-cycle pulse the cycle after Z was loaded
// BEHAVIOUR
// - Reset (sampled on clock edge, overrides enable): X=Y=Z=0; flag_c=flag_v=0; flag_z=1; z_strobe=0.
// - Register commands: 00 CLEAR (reg<=0), 01 HOLD, 10 LOAD, 11 reserved = HOLD.
// - LOAD sources:
//   - X <= data_in
//   - Y <= ula(Y,X,tula)
//   - Z <= Y
// - All sources use pre-edge register values:
//   - simultaneous X and Y LOAD: ALU uses the old X;
//   - Y and Z LOAD together: Z gets the old Y.
// - ALU ops (A=Y, B=X, result R WIDTH bits, wraps modulo 2^WIDTH):
//   - 000 ADD: R=A+B; c=carry out; v=signed overflow.
//   - 001 SUB: R=A-B; c=borrow (A<B unsigned); v=signed overflow.
//   - 010 SR: R=A>>1 logical; c=A[0]; v=0.
//   - 011 SL: R=A<<1; c=A[WIDTH-1]; v=A[WIDTH-1]^A[WIDTH-2].
//   - 1xx reserved: R=A; c=0; v=0.
// - Flags update only on the edge where Y is written:
//   - Y LOAD: flag_c/flag_v from ALU; flag_z = (R==0).
//   - Y CLEAR: c=v=0; flag_z=1.
//   - Y HOLD: flags hold.
// - z_strobe = registered (enable && tz==LOAD); high exactly one cycle per Z load; Z CLEAR does not strobe.
// - enable=0: every register, flag and Z holds; z_strobe=0 next cycle.
// - Latency: command to register value, 1 cycle; command to z_strobe, 1 cycle (same cycle z_out shows the new value).
// - No internal FSM beyond the registers; command sequencing belongs to controle.
// STRUCTURE
// - Shared package (xyz_pkg), also imported by controle:
//   - register command localparams REG_CLR=2'b00, REG_HOLD=2'b01, REG_LOAD=2'b10;
//   - ALU op localparams ULA_ADD=3'b000, ULA_SUB=3'b001, ULA_SR=3'b010, ULA_SL=3'b011.
// - One sub-module: ula, combinational, WIDTH-parameterised; inputs a, b, op; outputs r, c, v.
// - Top level holds X/Y/Z, the flag registers and the z_strobe flop.
// TESTING (WIDTH=4)
// - Reset asserted 2 cycles with random commands -> X=Y=Z=0, flag_z=1, c=v=0, z_strobe=0.
// - Clear+loadX: tx=10, ty=00, tz=00, data_in=5 -> X=5, Y=0, Z=0. Then ADD with tx=10, data_in=3
//   -> Y=5 (old X), X=3. Then SUB -> Y=2, c=0, v=0.
// - Y=7, X=1, ADD -> Y=8, v=1, c=0. Then SL -> Y=0, c=1, flag_z=1. Then SR on Y=0 -> Y=0, c=0.
// - SUB with Y=2, X=3 -> Y=15, c=1 (borrow), v=0.
// - Display: ty=01, tx=01, tz=10 with Y=9 -> Z=9 next cycle, z_strobe high exactly 1 cycle.
//   Same command with enable=0 -> no change, no strobe.
// - Reserved: tx=11 or tula=1xx with ty=10 -> X holds, Y unchanged, c=v=0.
//   Reset asserted mid-sequence -> all state cleared on that edge.

Source files
------------

// File: rtl/xyz_pkg.sv
// Shared encodings for the X/Y/Z datapath and the controle decoder that
// drives it: per-register commands and ALU operation codes.
package xyz_pkg;

  // Per-register command (tx/ty/tz). 2'b11 is reserved and behaves as HOLD.
  localparam logic [1:0] REG_CLR  = 2'b00;
  localparam logic [1:0] REG_HOLD = 2'b01;
  localparam logic [1:0] REG_LOAD = 2'b10;

  // ALU operation (tula). Codes 3'b1xx are reserved: result passes A through.
  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_SR  = 3'b010;
  localparam logic [2:0] ULA_SL  = 3'b011;

  // Status captured alongside every write of Y.
  typedef struct packed {
    logic c;  // carry / borrow / shifted-out bit
    logic v;  // signed overflow
    logic z;  // result was zero
  } flags_t;

endpackage : xyz_pkg

// File: rtl/datapath_xyz_ula.sv
// ula: combinational WIDTH-bit ALU. A is the accumulator (Y), B the operand
// (X). Returns the wrapped result plus carry/borrow and signed overflow.
module ula
  import xyz_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] r,
  output logic             c,
  output logic             v
);

  localparam int MSB = WIDTH - 1;

  // One extra bit catches the carry out of ADD and the borrow out of SUB:
  // the unsigned difference goes negative (top bit set) exactly when a < b.
  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] diff_w;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};

  // Operation select; reserved codes fall through to the pass-A default.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    r = a;
    c = 1'b0;
    v = 1'b0;
    case (op)
      ULA_ADD: begin
        r = sum_w[MSB:0];
        c = sum_w[WIDTH];
        // Overflow: operands share a sign that the result does not.
        v = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
      end
      ULA_SUB: begin
        r = diff_w[MSB:0];
        c = diff_w[WIDTH];
        // Overflow: operands differ in sign and the result flips from A's.
        v = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
      end
      ULA_SR: begin
        r = {1'b0, a[MSB:1]};
        c = a[0];
      end
      ULA_SL: begin
        r = {a[MSB-1:0], 1'b0};
        c = a[MSB];
        v = a[MSB] ^ a[MSB-1];
      end
      default: ;
    endcase
  end

endmodule : ula

// File: rtl/datapath_xyz.sv
// datapath_xyz: X/Y/Z register datapath sitting behind controle. X takes the
// external operand, Y accumulates the ALU result, Z latches Y for display.
// All loads use pre-edge register values, so a simultaneous X+Y load feeds
// the old X to the ALU and a simultaneous Y+Z load hands Z the old Y.
module datapath_xyz
  import xyz_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       tx,
  input  logic [1:0]       ty,
  input  logic [1:0]       tz,
  input  logic [2:0]       tula,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] z_out,
  output logic [WIDTH-1:0] y_out,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             z_strobe
);

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] z_q, z_d;
  flags_t           flags_q, flags_d;
  logic             strobe_q, strobe_d;

  logic [WIDTH-1:0] ula_r;
  logic             ula_c;
  logic             ula_v;

  ula #(.WIDTH(WIDTH)) u_ula (
    .a  (y_q),
    .b  (x_q),
    .op (tula),
    .r  (ula_r),
    .c  (ula_c),
    .v  (ula_v)
  );

  // Next-state decode of the three register commands and the Y flags.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    flags_d  = flags_q;
    // Strobe marks a Z LOAD only; CLEAR and disabled cycles leave it low.
    strobe_d = enable && (tz == REG_LOAD);

    if (enable) begin
      case (tx)
        REG_CLR:  x_d = '0;
        REG_LOAD: x_d = data_in;
        default:  ;  // HOLD and reserved
      endcase

      case (ty)
        REG_CLR: begin
          y_d     = '0;
          flags_d = '{c: 1'b0, v: 1'b0, z: 1'b1};
        end
        REG_LOAD: begin
          y_d     = ula_r;
          flags_d = '{c: ula_c, v: ula_v, z: (ula_r == '0)};
        end
        default: ;  // flags only move when Y is written
      endcase

      case (tz)
        REG_CLR:  z_d = '0;
        REG_LOAD: z_d = y_q;
        default:  ;
      endcase
    end
  end

  // State registers with synchronous reset that overrides enable.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, which is what makes the old-X/old-Y
    // forwarding rules hold without any extra logic.
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      flags_q  <= '{c: 1'b0, v: 1'b0, z: 1'b1};
      strobe_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      flags_q  <= flags_d;
      strobe_q <= strobe_d;
    end
  end

  assign z_out    = z_q;
  assign y_out    = y_q;
  assign flag_c   = flags_q.c;
  assign flag_v   = flags_q.v;
  assign flag_z   = flags_q.z;
  assign z_strobe = strobe_q;

endmodule : datapath_xyz

// File: tb/tb_datapath_xyz.sv
// Scoreboard bench for datapath_xyz (WIDTH=4). Each applied command set runs
// through an integer-arithmetic reference model; the predicted outputs are
// queued and compared one cycle later, after the edge that applies them.
module tb_datapath_xyz;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [1:0]   tx, ty, tz;
  logic [2:0]   tula;
  logic [W-1:0] data_in;
  logic [W-1:0] z_out, y_out;
  logic         flag_c, flag_v, flag_z, z_strobe;

  datapath_xyz #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .tx       (tx),
    .ty       (ty),
    .tz       (tz),
    .tula     (tula),
    .data_in  (data_in),
    .z_out    (z_out),
    .y_out    (y_out),
    .flag_c   (flag_c),
    .flag_v   (flag_v),
    .flag_z   (flag_z),
    .z_strobe (z_strobe)
  );

  always #5 clock = ~clock;

  typedef struct {
    string tag;
    int    z, y, c, v, zf, zs;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model state.
  int m_x, m_y, m_z, m_c, m_v, m_zf, m_zs;

  task automatic check(input string tag, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int sgn(input int u);
    return (u >= 8) ? u - 16 : u;
  endfunction

  // Advance the model by one edge and queue the outputs it predicts.
  task automatic model(input string tag, input int rst, input int en,
                       input int cx, input int cy, input int cz,
                       input int op, input int din);
    int r, c, v, s;
    exp_t e;
    if (rst != 0) begin
      m_x = 0; m_y = 0; m_z = 0; m_c = 0; m_v = 0; m_zf = 1; m_zs = 0;
    end else if (en == 0) begin
      m_zs = 0;
    end else begin
      r = m_y; c = 0; v = 0;
      case (op)
        0: begin
          s = m_y + m_x; r = s % 16; c = (s > 15);
          s = sgn(m_y) + sgn(m_x); v = (s > 7 || s < -8);
        end
        1: begin
          r = (m_y - m_x + 16) % 16; c = (m_y < m_x);
          s = sgn(m_y) - sgn(m_x); v = (s > 7 || s < -8);
        end
        2: begin r = m_y / 2; c = m_y % 2; end
        3: begin
          r = (m_y * 2) % 16; c = (m_y >= 8);
          s = sgn(m_y) * 2; v = (s > 7 || s < -8);
        end
        default: ;
      endcase
      if (cz == 0) m_z = 0; else if (cz == 2) m_z = m_y;
      if (cy == 0) begin m_y = 0; m_c = 0; m_v = 0; m_zf = 1; end
      else if (cy == 2) begin m_y = r; m_c = c; m_v = v; m_zf = (r == 0); end
      if (cx == 0) m_x = 0; else if (cx == 2) m_x = din;
      m_zs = (cz == 2);
    end
    e.tag = tag; e.z = m_z; e.y = m_y; e.c = m_c; e.v = m_v;
    e.zf = m_zf; e.zs = m_zs;
    exp_q.push_back(e);
  endtask

  // Drive one command set, let one edge apply it, then score the outputs.
  task automatic step(input string tag, input int rst, input int en,
                      input int cx, input int cy, input int cz,
                      input int op, input int din);
    exp_t e;
    reset   = (rst != 0);
    enable  = (en != 0);
    tx      = 2'(cx);
    ty      = 2'(cy);
    tz      = 2'(cz);
    tula    = 3'(op);
    data_in = W'(din);
    model(tag, rst, en, cx, cy, cz, op, din);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, ".z"},      int'(z_out),    e.z);
      check({e.tag, ".y"},      int'(y_out),    e.y);
      check({e.tag, ".c"},      int'(flag_c),   e.c);
      check({e.tag, ".v"},      int'(flag_v),   e.v);
      check({e.tag, ".zf"},     int'(flag_z),   e.zf);
      check({e.tag, ".strobe"}, int'(z_strobe), e.zs);
    end
  endtask

  // Load Y with a value by clearing it and adding X (X=val loaded first).
  task automatic set_y(input int val);
    step("sety_x", 0, 1, 2, 0, 1, 0, val);
    step("sety_y", 0, 1, 1, 2, 1, 0, 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; tx = '0; ty = '0; tz = '0;
    tula = '0; data_in = '0;
    m_x = 0; m_y = 0; m_z = 0; m_c = 0; m_v = 0; m_zf = 1; m_zs = 0;

    // Reset held two cycles while commands toggle randomly.
    for (int i = 0; i < 2; i++)
      step("reset", 1, 1, $urandom_range(3), $urandom_range(3),
           $urandom_range(3), $urandom_range(7), $urandom_range(15));

    // Clear + load X, then ADD using the old X while X reloads, then SUB.
    step("ldx5",  0, 1, 2, 0, 0, 0, 5);
    step("add_oldx", 0, 1, 2, 2, 1, 0, 3);   // Y=5, X=3
    step("sub52", 0, 1, 1, 2, 1, 1, 0);      // Y=2

    // Signed overflow on ADD, then shift-out to zero, then SR of zero.
    step("ldx7",  0, 1, 2, 0, 1, 0, 7);
    step("y7x1",  0, 1, 2, 2, 1, 0, 1);      // Y=7, X=1
    step("add_ovf", 0, 1, 1, 2, 1, 0, 0);    // Y=8, v=1
    step("sl_out", 0, 1, 1, 2, 1, 3, 0);     // Y=0, c=1, z=1
    step("sr_zero", 0, 1, 1, 2, 1, 2, 0);    // Y=0, c=0

    // Borrow: 2 - 3.
    step("ldx2",  0, 1, 2, 0, 1, 0, 2);
    step("y2x3",  0, 1, 2, 2, 1, 0, 3);
    step("sub_borrow", 0, 1, 1, 2, 1, 1, 0); // Y=15, c=1

    // Display Y=9 into Z: one strobe, then disabled repeat does nothing.
    set_y(9);
    step("disp",  0, 1, 1, 1, 2, 0, 0);
    step("disp_idle", 0, 1, 1, 1, 1, 0, 0);
    step("disp_dis", 0, 0, 0, 0, 2, 0, 4);

    // Y and Z load together: Z takes the old Y.
    step("yz_same", 0, 1, 1, 2, 2, 0, 0);    // Y=9+X, Z=9

    // Reserved X command and reserved ALU ops.
    step("tx_rsv", 0, 1, 3, 1, 1, 0, 12);
    step("ula_rsv4", 0, 1, 1, 2, 1, 4, 0);
    step("ula_rsv7", 0, 1, 3, 2, 1, 7, 0);
    step("zclr", 0, 1, 1, 1, 0, 0, 0);       // Z cleared, no strobe

    // Random traffic.
    for (int i = 0; i < 60; i++)
      step("rand", 0, ($urandom_range(7) != 0), $urandom_range(3),
           $urandom_range(3), $urandom_range(3), $urandom_range(7),
           $urandom_range(15));

    // Reset mid-sequence with a Z load pending.
    set_y(6);
    step("pre_rst", 0, 1, 1, 1, 2, 0, 0);
    step("mid_rst", 1, 1, 2, 2, 2, 0, 11);
    step("post_rst", 0, 1, 1, 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_datapath_xyz
